max_stream_finder: RTL and testbench
====================================

Name: max_stream_finder

Overview:
- Streaming, multi-lane successor to the combinational max finder.
- Accepts frames of vectors, LANES elements per beat, over a valid/ready stream and tracks the running extreme value and its global element index.
- Emits one result per frame on a registered valid/ready output.
- Sits between feature/score producers and downstream decision logic (argmax/argmin over arbitrarily long frames).

Parameters:
- WIDTH, 8, element bit width.
- LANES, 4, elements per input beat; ≥1, any integer.
- IDX_WIDTH, 16, bit width of the global element index and of the element count; must be ≥ $clog2(LANES)+1.
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.
- FIND_MIN, 0, 1 = find minimum, 0 = find maximum.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  [LANES][WIDTH]  lane elements; lane 0 is the lowest index.
- s_keep  in  LANES  per-lane enable; lanes with keep=0 are ignored for compare and count.
- s_last  in  1  final beat of frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid && m_ready.
- m_value  out  WIDTH  extreme value of frame.
- m_index  out  IDX_WIDTH  global index = beat_number*LANES + lane.
- m_count  out  IDX_WIDTH  number of kept elements in frame, saturating.
- m_overflow  out  1  frame exceeded the index range.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_value=0, m_index=0, m_count=0, m_overflow=0. FSM returns to IDLE and the accumulator is cleared. A partial frame in progress is discarded, with no result.
- s_ready = !m_valid || m_ready (combinational). The only backpressure is a held, unconsumed result.
- Intra-beat: combinational reduction over kept lanes.
  - Winner = greater value (smaller if FIND_MIN).
  - Ties go to the lower lane.
  - Compare is signed when SIGNED=1.
- Inter-beat: the beat winner replaces the accumulator only if strictly better, so ties keep the earlier element. Overall tie rule: lowest global index wins.
- FSM states:
  - IDLE: no frame open, accumulator empty. An accepted beat opens a frame.
    - If s_last is also set, the result is produced from that beat alone and the FSM stays in IDLE.
    - Otherwise the FSM moves to ACCUM.
  - ACCUM: each accepted beat updates the accumulator. An accepted beat with s_last goes to IDLE and loads the output.
- The first kept element of a frame always loads the accumulator unconditionally.
- Beat counter:
  - Increments on every accepted beat, including beats with s_keep=0.
  - Element index of lane L in beat B is B*LANES+L.
- Overflow:
  - If any kept lane's index would exceed 2^IDX_WIDTH-1, set sticky m_overflow for the frame.
  - That beat and all later beats are consumed but do not update value/index.
  - m_count saturates at 2^IDX_WIDTH-1.
- Latency: the result appears on m_valid the cycle after the s_last beat is accepted, and includes that beat.
- m_* outputs are held stable while m_valid && !m_ready.
- Simultaneous m_ready and last-beat acceptance: the old result is consumed and the new result is loaded in the same edge, so m_valid stays 1.
- Back-to-back frames:
  - The next frame's first beat may be accepted on the cycle after the previous s_last.
  - The accumulator is cleared by the s_last acceptance, so the next frame needs no bubble.
- Empty frame (all beats have keep=0): result with m_count=0, m_value=0, m_index=0, m_overflow=0.
- LANES=1 degenerates to a serial scanner.

Test Plan:
1. Unsigned max, LANES=4, one frame of 2 beats: [3,9,2,9] then [9,1,0,4] with s_last on beat 2 -> m_value=9, m_index=1, m_count=8, m_valid one cycle after the last beat.
2. SIGNED=1, FIND_MIN=1, beats [5,-3,7,-3] and [-8,0,0,0] -> m_value=-8 (0xF8), m_index=4. Repeat with SIGNED=0 -> m_value=0, m_index=5.
3. s_keep: beat 1 keep=4'b0000, beat 2 data [1,50,2,3] keep=4'b1010, last -> m_value=50, m_index=5, m_count=2. Also an all-zero-keep single-beat frame -> m_count=0, m_value=0, m_index=0.
4. Backpressure: hold m_ready=0 with a result pending -> s_ready=0, outputs stable for 5 cycles. Then assert m_ready in the same cycle as the next frame's last beat -> m_valid stays 1 and the new result loads.
5. IDX_WIDTH=4, LANES=4: 5-beat frame with the maximum 200 in beat 5 lane 0 -> m_overflow=1, m_count=15, m_index/m_value from the first 4 beats.
6. Assert rst_n low mid-frame after 2 beats, release, then send a 1-beat frame [7,7,1,1] -> all outputs 0 during reset; result m_value=7, m_index=0, m_count=4, with no residue from the aborted frame.

Source files
------------

// File: rtl/max_stream_finder.sv
// -----------------------------------------------------------------------------
// max_stream_finder
//   Streaming argmax/argmin over frames of LANES-wide beats. Each accepted beat
//   is reduced across its kept lanes and merged into a running accumulator; the
//   frame's extreme value, its global element index, the kept-element count and
//   an overflow flag are emitted once per frame on a registered valid/ready port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     input beat handshake (s_ready = !m_valid || m_ready)
//   s_data              LANES x WIDTH elements, lane 0 = lowest index
//   s_keep              per-lane enable; dropped lanes neither compete nor count
//   s_last              last beat of the frame
//   m_valid/m_ready     result handshake
//   m_value, m_index    extreme value and its global index (beat*LANES + lane)
//   m_count             kept elements in the frame, saturating
//   m_overflow          some kept element's index did not fit in IDX_WIDTH
// -----------------------------------------------------------------------------

// One link of the intra-beat compare chain. The incoming candidate is replaced
// only by a strictly better kept element, so equal values stay with the lower
// lane (and, since the chain is seeded with the accumulator, the earlier beat).
module msf_lane #(
  parameter int WIDTH    = 8,
  parameter int EW       = 17,
  parameter int SIGNED   = 0,
  parameter int FIND_MIN = 0
) (
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_val,
  input  logic [EW-1:0]    in_idx,
  input  logic             keep,
  input  logic [WIDTH-1:0] data,
  input  logic [EW-1:0]    idx,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_val,
  output logic [EW-1:0]    out_idx,
  output logic             ovf
);
  logic gt, lt, better, take;

  always_comb begin
    if (SIGNED != 0) begin
      gt = $signed(data) > $signed(in_val);
      lt = $signed(data) < $signed(in_val);
    end else begin
      gt = data > in_val;
      lt = data < in_val;
    end
    better  = (FIND_MIN != 0) ? lt : gt;
    take    = keep && (!in_vld || better);
    out_vld = in_vld || keep;
    out_val = take ? data : in_val;
    out_idx = take ? idx  : in_idx;
    // MSB of the extended index set means the element lies past 2^IDX_WIDTH-1
    ovf     = keep && idx[EW-1];
  end
endmodule

module max_stream_finder #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int IDX_WIDTH = 16,
  parameter int SIGNED    = 0,
  parameter int FIND_MIN  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES-1:0][WIDTH-1:0] s_data,
  input  logic [LANES-1:0]            s_keep,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_value,
  output logic [IDX_WIDTH-1:0]        m_index,
  output logic [IDX_WIDTH-1:0]        m_count,
  output logic                        m_overflow
);
  // One extra index bit: with IDX_WIDTH >= clog2(LANES)+1, base+lane of any
  // beat starting in range fits, and the MSB flags out-of-range elements.
  localparam int EW = IDX_WIDTH + 1;
  localparam int PW = $clog2(LANES + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]     value;
    logic [IDX_WIDTH-1:0] index;
    logic [IDX_WIDTH-1:0] count;
    logic                 overflow;
  } res_t;

  state_t               state;
  logic                 acc_vld;
  logic [WIDTH-1:0]     acc_val;
  logic [IDX_WIDTH-1:0] acc_idx;
  logic [EW-1:0]        base;     // global index of lane 0 of the next beat
  logic [IDX_WIDTH-1:0] cnt;
  logic                 fovf;     // sticky frame overflow
  res_t                 res;

  // compare chain: slot 0 is the accumulator, slot LANES the merged winner
  logic [LANES:0]                c_vld;
  logic [LANES:0][WIDTH-1:0]     c_val;
  logic [LANES:0][EW-1:0]        c_idx;
  logic [LANES-1:0][EW-1:0]      l_idx;
  logic [LANES-1:0]              l_ovf;

  logic                 accept;
  logic [PW-1:0]        pop;
  logic [EW-1:0]        cnt_sum;
  logic [IDX_WIDTH-1:0] cnt_nxt;
  logic [EW-1:0]        base_nxt;
  logic                 ovf_nxt, upd;
  logic                 nxt_vld;
  logic [WIDTH-1:0]     nxt_val;
  logic [IDX_WIDTH-1:0] nxt_idx;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // IDLE means no frame is open: the accumulator never competes there
  assign c_vld[0] = acc_vld && (state == ACCUM);
  assign c_val[0] = acc_val;
  assign c_idx[0] = {1'b0, acc_idx};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign l_idx[g] = base + EW'(g);
    msf_lane #(
      .WIDTH(WIDTH), .EW(EW), .SIGNED(SIGNED), .FIND_MIN(FIND_MIN)
    ) u_lane (
      .in_vld (c_vld[g]),
      .in_val (c_val[g]),
      .in_idx (c_idx[g]),
      .keep   (s_keep[g]),
      .data   (s_data[g]),
      .idx    (l_idx[g]),
      .out_vld(c_vld[g+1]),
      .out_val(c_val[g+1]),
      .out_idx(c_idx[g+1]),
      .ovf    (l_ovf[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(s_keep[i]);
    cnt_sum  = {1'b0, cnt} + EW'(pop);
    cnt_nxt  = cnt_sum[IDX_WIDTH] ? {IDX_WIDTH{1'b1}} : cnt_sum[IDX_WIDTH-1:0];
    // base saturates once past the index range; every later element overflows
    base_nxt = base[IDX_WIDTH] ? base : base + EW'(LANES);
    ovf_nxt  = fovf || (|l_ovf);
    // an overflowing beat, and every beat after it, leaves the winner alone
    upd      = !ovf_nxt && !c_idx[LANES][EW-1];
    nxt_vld  = upd ? c_vld[LANES] : c_vld[0];
    nxt_val  = upd ? c_val[LANES] : acc_val;
    nxt_idx  = upd ? c_idx[LANES][IDX_WIDTH-1:0] : acc_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_vld <= 1'b0;
      acc_val <= '0;
      acc_idx <= '0;
      base    <= '0;
      cnt     <= '0;
      fovf    <= 1'b0;
      res     <= '0;
      m_valid <= 1'b0;
    end else begin
      if (m_ready) m_valid <= 1'b0;
      if (accept) begin
        if (s_last) begin
          // result includes this beat; clearing here lets the next frame
          // start on the very next cycle
          res.value    <= nxt_vld ? nxt_val : '0;
          res.index    <= nxt_vld ? nxt_idx : '0;
          res.count    <= cnt_nxt;
          res.overflow <= ovf_nxt;
          m_valid      <= 1'b1;
          state        <= IDLE;
          acc_vld      <= 1'b0;
          acc_val      <= '0;
          acc_idx      <= '0;
          base         <= '0;
          cnt          <= '0;
          fovf         <= 1'b0;
        end else begin
          state   <= ACCUM;
          acc_vld <= nxt_vld;
          acc_val <= nxt_val;
          acc_idx <= nxt_idx;
          base    <= base_nxt;
          cnt     <= cnt_nxt;
          fovf    <= ovf_nxt;
        end
      end
    end
  end

  assign m_value    = res.value;
  assign m_index    = res.index;
  assign m_count    = res.count;
  assign m_overflow = res.overflow;
endmodule

// File: tb/tb_max_stream_finder.sv
// Four instances share one stimulus stream:
//   0: unsigned max, IDX_WIDTH=16   1: signed min, IDX_WIDTH=16
//   2: unsigned min, IDX_WIDTH=16   3: unsigned max, IDX_WIDTH=4
// A frame-level reference model keeps the kept elements of the open frame and
// derives each instance's result when the last beat is accepted.
module tb_max_stream_finder;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                s_valid, s_last, m_ready;
  logic [L-1:0][W-1:0] s_data;
  logic [L-1:0]        s_keep;
  logic [3:0]          s_ready, m_valid, m_overflow;
  logic [3:0][W-1:0]   m_value_a;
  logic [2:0][15:0]    m_index_a, m_count_a;
  logic [3:0]          m_index3, m_count3;

  max_stream_finder #(.WIDTH(W), .LANES(L), .IDX_WIDTH(16), .SIGNED(0), .FIND_MIN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_value(m_value_a[0]), .m_index(m_index_a[0]), .m_count(m_count_a[0]), .m_overflow(m_overflow[0]));
  max_stream_finder #(.WIDTH(W), .LANES(L), .IDX_WIDTH(16), .SIGNED(1), .FIND_MIN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_value(m_value_a[1]), .m_index(m_index_a[1]), .m_count(m_count_a[1]), .m_overflow(m_overflow[1]));
  max_stream_finder #(.WIDTH(W), .LANES(L), .IDX_WIDTH(16), .SIGNED(0), .FIND_MIN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[2]), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid[2]), .m_ready(m_ready),
    .m_value(m_value_a[2]), .m_index(m_index_a[2]), .m_count(m_count_a[2]), .m_overflow(m_overflow[2]));
  max_stream_finder #(.WIDTH(W), .LANES(L), .IDX_WIDTH(4), .SIGNED(0), .FIND_MIN(0)) u3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[3]), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid[3]), .m_ready(m_ready),
    .m_value(m_value_a[3]), .m_index(m_index3), .m_count(m_count3), .m_overflow(m_overflow[3]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_idx(input int c);
    return (c == 3) ? 32'(m_index3) : 32'(m_index_a[c]);
  endfunction
  function automatic logic [31:0] get_cnt(input int c);
    return (c == 3) ? 32'(m_count3) : 32'(m_count_a[c]);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {int val; int bt; int lane;} el_t;
  el_t fq[$];
  int  nbeat;
  bit  exp_mv;
  int  exp_val[4], exp_idx[4], exp_cnt[4], exp_ovf[4];
  int  SGN[4] = '{0, 1, 0, 0};
  int  FMN[4] = '{0, 1, 1, 0};
  int  IWS[4] = '{16, 16, 16, 4};

  // larger key = better element for configuration c
  function automatic int key(input int c, input int v);
    int k;
    k = (SGN[c] != 0 && v >= 128) ? v - 256 : v;
    return (FMN[c] != 0) ? -k : k;
  endfunction

  task automatic model_reset();
    fq.delete();
    nbeat  = 0;
    exp_mv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_val[c] = 0; exp_idx[c] = 0; exp_cnt[c] = 0; exp_ovf[c] = 0;
    end
  endtask

  task automatic finish_frame();
    for (int c = 0; c < 4; c++) begin
      int maxi, ob, bestk, bi, bv;
      bit found;
      maxi = (1 << IWS[c]) - 1;
      ob   = 1 << 30;
      foreach (fq[i])
        if (fq[i].bt * L + fq[i].lane > maxi && fq[i].bt < ob) ob = fq[i].bt;
      found = 1'b0; bestk = 0; bi = 0; bv = 0;
      // queue is in ascending index order, so strict '>' keeps the lowest index
      foreach (fq[i])
        if (fq[i].bt < ob && (!found || key(c, fq[i].val) > bestk)) begin
          found = 1'b1; bestk = key(c, fq[i].val);
          bi = fq[i].bt * L + fq[i].lane; bv = fq[i].val;
        end
      exp_val[c] = bv;
      exp_idx[c] = bi;
      exp_cnt[c] = (fq.size() > maxi) ? maxi : fq.size();
      exp_ovf[c] = (ob != (1 << 30)) ? 1 : 0;
    end
    fq.delete();
    nbeat = 0;
  endtask

  // ---------------- drivers / checks ----------------
  task automatic chk_out();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("m_valid[%0d]", c), 32'(m_valid[c]), 32'(exp_mv));
      if (exp_mv) begin
        chk($sformatf("m_value[%0d]", c), 32'(m_value_a[c]), exp_val[c]);
        chk($sformatf("m_index[%0d]", c), get_idx(c), exp_idx[c]);
        chk($sformatf("m_count[%0d]", c), get_cnt(c), exp_cnt[c]);
        chk($sformatf("m_overflow[%0d]", c), 32'(m_overflow[c]), exp_ovf[c]);
      end
    end
  endtask

  task automatic zero_chk(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_mv"}, 32'(m_valid[c]), 0);
      chk({tag, "_val"}, 32'(m_value_a[c]), 0);
      chk({tag, "_idx"}, get_idx(c), 0);
      chk({tag, "_cnt"}, get_cnt(c), 0);
      chk({tag, "_ovf"}, 32'(m_overflow[c]), 0);
    end
  endtask

  // one clock: called and returns at a falling edge
  task automatic step(input bit v, input bit last, input logic [L-1:0][W-1:0] d,
                      input logic [L-1:0] k, input bit mr, output bit acc);
    s_valid = v; s_last = last; s_data = d; s_keep = k; m_ready = mr;
    #1;
    for (int c = 0; c < 4; c++)
      chk($sformatf("s_ready[%0d]", c), 32'(s_ready[c]), 32'(!exp_mv || mr));
    acc = v && (!exp_mv || mr);
    @(posedge clk);
    if (acc) begin
      for (int l = 0; l < L; l++)
        if (k[l]) fq.push_back('{int'(d[l]), nbeat, l});
      nbeat++;
    end
    if (acc && last) begin
      finish_frame();
      exp_mv = 1'b1;
    end else if (mr) exp_mv = 1'b0;
    @(negedge clk);
    chk_out();
  endtask

  bit rnd_mr = 1'b0;

  task automatic send_beat(input logic [L-1:0][W-1:0] d, input logic [L-1:0] k, input bit last);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, last, d, k, rnd_mr ? bit'($urandom % 2) : 1'b1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  function automatic logic [L-1:0][W-1:0] p4(input int a, input int b, input int c, input int d);
    logic [L-1:0][W-1:0] r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
    return r;
  endfunction

  task automatic do_reset();
    bit acc;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    zero_chk("rst_async");
    @(negedge clk);
    zero_chk("rst_hold");
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; m_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    zero_chk("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: unsigned max, tie between lanes/beats goes to index 1
    send_beat(p4(3, 9, 2, 9), 4'hF, 1'b0);
    chk("t1_mv_early", 32'(m_valid[0]), 0);
    send_beat(p4(9, 1, 0, 4), 4'hF, 1'b1);
    chk("t1_mv", 32'(m_valid[0]), 1);
    chk("t1_val", 32'(m_value_a[0]), 9);
    chk("t1_idx", get_idx(0), 1);
    chk("t1_cnt", get_cnt(0), 8);

    // 2: signed min vs unsigned min
    send_beat(p4(5, 8'hFD, 7, 8'hFD), 4'hF, 1'b0);
    send_beat(p4(8'hF8, 0, 0, 0), 4'hF, 1'b1);
    chk("t2_smin_val", 32'(m_value_a[1]), 32'hF8);
    chk("t2_smin_idx", get_idx(1), 4);
    chk("t2_umin_val", 32'(m_value_a[2]), 0);
    chk("t2_umin_idx", get_idx(2), 5);

    // 3: keep masking, then an empty frame
    send_beat(p4(99, 99, 99, 99), 4'h0, 1'b0);
    send_beat(p4(1, 50, 2, 3), 4'b1010, 1'b1);
    chk("t3_val", 32'(m_value_a[0]), 50);
    chk("t3_idx", get_idx(0), 5);
    chk("t3_cnt", get_cnt(0), 2);
    send_beat(p4(200, 201, 202, 203), 4'h0, 1'b1);
    chk("t3e_val", 32'(m_value_a[0]), 0);
    chk("t3e_idx", get_idx(0), 0);
    chk("t3e_cnt", get_cnt(0), 0);

    // 4: backpressure, then m_ready together with the next last beat
    repeat (5) step(1'b0, 1'b0, '0, '0, 1'b0, acc);
    chk("t4_hold_mv", 32'(m_valid[0]), 1);
    chk("t4_hold_rdy", 32'(s_ready[0]), 0);
    step(1'b1, 1'b1, p4(10, 20, 30, 40), 4'hF, 1'b0, acc);
    chk("t4_blocked", 32'(acc), 0);
    step(1'b1, 1'b1, p4(10, 20, 30, 40), 4'hF, 1'b1, acc);
    chk("t4_mv", 32'(m_valid[0]), 1);
    chk("t4_val", 32'(m_value_a[0]), 40);
    chk("t4_idx", get_idx(0), 3);

    // 5: overflow on the IDX_WIDTH=4 instance
    for (int b = 0; b < 4; b++)
      send_beat(p4(10*b+1, 10*b+2, 10*b+3, 10*b+4), 4'hF, 1'b0);
    send_beat(p4(200, 0, 0, 0), 4'hF, 1'b1);
    chk("t5_ovf", 32'(m_overflow[3]), 1);
    chk("t5_cnt", get_cnt(3), 15);
    chk("t5_val", 32'(m_value_a[3]), 34);
    chk("t5_idx", get_idx(3), 15);
    chk("t5_wide_val", 32'(m_value_a[0]), 200);
    chk("t5_wide_ovf", 32'(m_overflow[0]), 0);

    // 6: reset mid-frame, no residue
    send_beat(p4(250, 250, 250, 250), 4'hF, 1'b0);
    send_beat(p4(251, 251, 251, 251), 4'hF, 1'b0);
    do_reset();
    send_beat(p4(7, 7, 1, 1), 4'hF, 1'b1);
    chk("t6_val", 32'(m_value_a[0]), 7);
    chk("t6_idx", get_idx(0), 0);
    chk("t6_cnt", get_cnt(0), 4);

    // randomized frames with gaps, sparse keeps and random m_ready
    rnd_mr = 1'b1;
    for (int f = 0; f < 80; f++) begin
      int nb;
      nb = $urandom_range(1, 7);
      for (int b = 0; b < nb; b++) begin
        logic [L-1:0][W-1:0] d;
        logic [L-1:0] k;
        if ($urandom % 4 == 0) step(1'b0, 1'b0, '0, '0, bit'($urandom % 2), acc);
        d = $urandom;
        if ($urandom % 8 == 0) d = {L{d[0]}};
        k = ($urandom % 3 == 0) ? L'($urandom) : {L{1'b1}};
        send_beat(d, k, b == nb - 1);
      end
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
